// File: rtl/byte_serializer_pkg.sv
// Shared types and constants for the byte serializer: FSM state encoding and
// async-serial frame levels.
package byte_serializer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Bit timer needs at least one bit even when each serial bit is one cycle.
  function automatic int unsigned timer_width(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Free-running divider that pulses tick on the last cycle of every serial bit
// period; clear restarts the period from zero.
module bit_timer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = timer_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] TermCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (count_q == TermCnt) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tick = (count_q == TermCnt);

endmodule

// File: rtl/byte_serializer.sv
// Valid/ready byte sink that transmits each byte as a 10-bit async-serial
// frame (start 0, 8 data bits LSB first, stop 1) with CLKS_PER_BIT cycles/bit.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  state_e     state_q;
  logic [7:0] shift_q;
  logic [2:0] idx_q;
  logic       tx_q;
  logic       tick;
  logic       accept;

  assign accept = (state_q == StIdle) && valid_in;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= STOP_LEVEL;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_in) begin
            shift_q <= data_in;
            idx_q   <= '0;
            tx_q    <= START_LEVEL;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (tick) begin
            if (idx_q == 3'(DATA_BITS - 1)) begin
              tx_q    <= STOP_LEVEL;
              state_q <= StStop;
            end else begin
              // Drive the next bit straight from the pre-shift register.
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
              tx_q    <= shift_q[1];
            end
          end
        end
        StStop: begin
          if (tick) begin
            tx_q    <= STOP_LEVEL;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // All outputs decode registered state only, so none can follow data_in.
  assign tx        = tx_q;
  assign ready_out = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StStop) && tick;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: one instance at 4 clocks/bit and one at
// 1 clock/bit, checked against hand-written frame patterns.
module tb_byte_serializer;

  logic       clk;
  logic       reset4, valid4, tx4, ready4, busy4, done4;
  logic [7:0] data4;
  logic       reset1, valid1, tx1, ready1, busy1, done1;
  logic [7:0] data1;

  bit   sel;
  logic tx_s, ready_s, busy_s, done_s;

  int compared;
  int mismatched;

  byte_serializer #(
    .CLKS_PER_BIT(4)
  ) dut4 (
    .clk      (clk),
    .reset    (reset4),
    .data_in  (data4),
    .valid_in (valid4),
    .ready_out(ready4),
    .tx       (tx4),
    .busy     (busy4),
    .done     (done4)
  );

  byte_serializer #(
    .CLKS_PER_BIT(1)
  ) dut1 (
    .clk      (clk),
    .reset    (reset1),
    .data_in  (data1),
    .valid_in (valid1),
    .ready_out(ready1),
    .tx       (tx1),
    .busy     (busy1),
    .done     (done1)
  );

  assign tx_s    = sel ? tx1 : tx4;
  assign ready_s = sel ? ready1 : ready4;
  assign busy_s  = sel ? busy1 : busy4;
  assign done_s  = sel ? done1 : done4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"}, 32'(tx_s), 32'd1);
    check({tag, " ready"}, 32'(ready_s), 32'd1);
    check({tag, " busy"}, 32'(busy_s), 32'd0);
    check({tag, " done"}, 32'(done_s), 32'd0);
  endtask

  // Called at the first negedge after the accepting edge; returns at the
  // negedge after E(10N).
  task automatic run_frame(input string tag, input logic [9:0] frame, input int n,
                           input bit keep_valid);
    for (int j = 0; j < 10 * n; j++) begin
      check($sformatf("%s tx c%0d", tag, j), 32'(tx_s), 32'(frame[j/n]));
      check($sformatf("%s done c%0d", tag, j), 32'(done_s), 32'(j == 10 * n - 1));
      if (j == 0) begin
        check({tag, " busy"}, 32'(busy_s), 32'd1);
        check({tag, " ready"}, 32'(ready_s), 32'd0);
        if (!keep_valid) begin
          if (sel) valid1 = 1'b0;
          else valid4 = 1'b0;
        end
      end
      @(negedge clk);
    end
    check_idle({tag, " end"});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    sel        = 1'b0;
    reset4     = 1'b1;
    reset1     = 1'b1;
    valid4     = 1'b0;
    valid1     = 1'b0;
    data4      = 8'h00;
    data1      = 8'h00;

    // Reset state after the first edge, then stable with valid low.
    @(negedge clk);
    check_idle("rst");
    reset4 = 1'b0;
    reset1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("quiet%0d", i));
    end

    // Single 0xA5 frame.
    valid4 = 1'b1;
    data4  = 8'hA5;
    @(negedge clk);
    run_frame("a5", 10'b1101001010, 4, 1'b0);

    // valid held high: 0x3C then 0xFF queued, data_in changed mid-frame.
    valid4 = 1'b1;
    data4  = 8'h3C;
    @(negedge clk);
    data4 = 8'hFF;
    run_frame("3c", 10'b1001111000, 4, 1'b1);
    @(negedge clk);
    run_frame("ff", 10'b1111111110, 4, 1'b0);

    // 0x81 frame abandoned by reset in cycle 17.
    valid4 = 1'b1;
    data4  = 8'h81;
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("81 tx c%0d", j), 32'(tx_s), 32'(j / 4 == 1));
      if (j == 0) valid4 = 1'b0;
      @(negedge clk);
    end
    reset4 = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    reset4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle($sformatf("norsm%0d", i));
    end
    valid4 = 1'b1;
    data4  = 8'h55;
    @(negedge clk);
    run_frame("55", 10'b1010101010, 4, 1'b0);

    // Handshake coincident with reset is not accepted.
    reset4 = 1'b1;
    valid4 = 1'b1;
    data4  = 8'h00;
    @(negedge clk);
    check_idle("rstvld");
    reset4 = 1'b0;
    valid4 = 1'b0;
    @(negedge clk);
    check_idle("rstvld2");

    // One clock per bit.
    sel    = 1'b1;
    valid1 = 1'b1;
    data1  = 8'h01;
    @(negedge clk);
    run_frame("01", 10'b1000000010, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Downstream consumer of the 8-bit counter/pattern generator. Takes one byte per valid/ready handshake and shifts it out on a single-wire asynchronous-serial line as a 10-bit frame: start bit 0, eight data bits LSB first, stop bit 1. Each bit is held for a fixed number of clock cycles. It is the transmit end of the lab's byte path toward an off-board or bench receiver.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..65535.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  8  byte to transmit; sampled only on acceptance.
- valid_in  in  1  producer has a byte on data_in.
- ready_out  out  1  block can accept a byte this cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- Acceptance: a rising edge where valid_in=1 and ready_out=1.
  - data_in is latched into the shift register.
  - The bit counter clears and the state goes to START.
- ready_out = 1 only in IDLE. busy = not IDLE.
- tx per state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift_reg[0].
  - STOP: 1.
  - tx is registered; it never glitches with data_in.
- Bit timer: counts 0..CLKS_PER_BIT-1. At terminal count:
  - START goes to DATA.
  - In DATA, the register shifts right and the bit index increments.
  - After data bit 7, DATA goes to STOP.
  - STOP goes to IDLE; done is high during STOP's terminal-count cycle.
- valid_in and data_in are ignored outside IDLE.
- Changing data_in after acceptance has no effect on the frame in flight.
- Back-to-back: after STOP, the block spends at least one cycle in IDLE with ready_out=1. A valid byte there is accepted and the next start bit begins immediately; no extra idle bits are inserted.
- Reset (priority over everything):
  - State goes to IDLE; the bit timer and bit index clear.
  - tx=1, ready_out=1, busy=0, done=0 on the edge after reset is sampled high.
  - Any frame in flight is abandoned and never resumed.
  - A handshake in the same cycle as reset is not accepted.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; the frame is 10 cycles.

## Timing
- Let acceptance be edge E0.
- tx=0 in cycles E0..E(N), where N = CLKS_PER_BIT.
- Data bit k is driven in E((k+1)·N)..E((k+2)·N).
- Stop bit is driven in E(9N)..E(10N).
- done is high for the single cycle ending at E(10N). At E(10N), state=IDLE and ready_out=1.
- Latency from acceptance to start bit on tx: 1 edge.
- Frame length: exactly 10·N cycles.
- Minimum accept-to-accept spacing: 10·N + 1 cycles.
- Counter widths:
  - bit timer: $clog2(CLKS_PER_BIT), minimum 1 bit.
  - bit index: 3 bits.
  - No arithmetic wraps mid-frame.

## Structure
- Shared package byte_serializer_pkg:
  - state enum (IDLE, START, DATA, STOP), 2 bits.
  - FRAME_BITS=10, DATA_BITS=8.
  - START_LEVEL=0, STOP_LEVEL=1.
- Sub-module bit_timer (parameter CLKS_PER_BIT):
  - inputs: clk, reset, clear.
  - output: tick, high on the terminal count.
  - The FSM clears it on acceptance.
- Top level holds the FSM, the shift register, the bit index and the output registers.

## Test plan
1. Reset with CLKS_PER_BIT=4 -> after the first reset edge, tx=1, ready_out=1, busy=0, done=0; they stay that way with valid_in=0.
2. Send 0xA5 -> tx emits 0,1,0,1,0,0,1,0,1,1, each level held for 4 cycles (40 cycles total). done pulses exactly once at cycle 40. ready_out returns to 1 at E40.
3. valid_in held high with 0x3C then 0xFF queued -> second acceptance occurs exactly one IDLE cycle after the first frame. Second frame is 0, eight 1s, 1. data_in changes mid-frame do not alter the first frame.
4. Assert reset in cycle 17 of the 0x81 frame -> next edge tx=1, busy=0, ready_out=1, no done pulse. A new 0x55 frame then transmits correctly.
5. CLKS_PER_BIT=1, send 0x01 -> 10-cycle frame 0,1,0,0,0,0,0,0,0,1; done is high in cycle 10.
6. valid_in asserted together with reset -> no acceptance; tx stays 1 and busy stays 0.
